// File: rtl/lmc_ram.sv
// Self-clearing single-port LMC data memory: synchronous write, zero-fill sweep after reset or clr.
// Optional build macro LMC_RAM_REG_OUT_EN registers RAM_out (one-cycle read latency).
module lmc_ram #(
   parameter int N = 2,
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         we,
   input  logic         clr,
   input  logic [N-1:0] adr,
   input  logic [M-1:0] data_in,
   output logic [M-1:0] RAM_out,
   output logic         busy
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam logic [N-1:0] PTR_ZERO = {N{1'b0}};
   localparam logic [N-1:0] PTR_LAST = {N{1'b1}};
   localparam logic [N-1:0] PTR_ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [M-1:0] WORD_ZERO = {M{1'b0}};

   state_t         state_r, state_s;
   logic [N-1:0]   ptr_r, ptr_s;
   logic           wr_en_s;
   logic [N-1:0]   wr_adr_s;
   logic [M-1:0]   wr_data_s;
   logic [M-1:0]   rd_data_s;
   logic [M-1:0]   mem_r [0:2**N-1];

   // State and sweep pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CLEAR;
         ptr_r   <= PTR_ZERO;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
      end
   end

   // Next-state and write-port steering; the sweep owns the write port while clearing
   always_comb begin
      state_s   = state_r;
      ptr_s     = ptr_r;
      wr_en_s   = 1'b0;
      wr_adr_s  = adr;
      wr_data_s = data_in;
      case (state_r)
         CLEAR: begin
            wr_en_s   = 1'b1;
            wr_adr_s  = ptr_r;
            wr_data_s = WORD_ZERO;
            if (ptr_r == PTR_LAST) begin
               ptr_s   = PTR_ZERO;
               state_s = IDLE;
            end else begin
               ptr_s   = ptr_r + PTR_ONE;
            end
         end
         IDLE: begin
            if (clr) begin
               state_s = CLEAR;
               ptr_s   = PTR_ZERO;
            end else if (we) begin
               wr_en_s = 1'b1;
            end else begin
               wr_en_s = 1'b0;
            end
         end
         default: begin
            state_s = CLEAR;
            ptr_s   = PTR_ZERO;
         end
      endcase
   end

   // Memory array write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_adr_s] <= wr_data_s;
      end
   end

   assign busy      = (state_r == CLEAR);
   assign rd_data_s = busy ? WORD_ZERO : mem_r[adr];

`ifdef LMC_RAM_REG_OUT_EN
   logic [M-1:0] ram_out_r;

   // Registered read port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_out_r <= WORD_ZERO;
      end else begin
         ram_out_r <= rd_data_s;
      end
   end

   assign RAM_out = ram_out_r;
`else
   assign RAM_out = rd_data_s;
`endif

endmodule

// File: tb/tb_lmc_ram.sv
// Directed self-checking bench for lmc_ram (N=2, M=4).
module tb_lmc_ram;

   logic       clk;
   logic       rst_n;
   logic       we;
   logic       clr;
   logic [1:0] adr;
   logic [3:0] data_in;
   logic [3:0] RAM_out;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int n;

   lmc_ram #(.N(2), .M(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (we),
      .clr     (clr),
      .adr     (adr),
      .data_in (data_in),
      .RAM_out (RAM_out),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d);
      adr = a; data_in = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [3:0] exp);
      adr = a;
`ifdef LMC_RAM_REG_OUT_EN
      tick();
`else
      #1;
`endif
      check(tag, {28'd0, RAM_out}, {28'd0, exp});
   endtask

   // Counts edges while busy; expects busy already high on entry
   task automatic sweep(input string tag);
      n = 0;
      while (busy && n < 20) begin
`ifndef LMC_RAM_REG_OUT_EN
         check({tag, "_out0"}, {28'd0, RAM_out}, 32'd0);
`endif
         tick();
         n++;
      end
      check({tag, "_len"}, n, 32'd4);
      check({tag, "_done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; clr = 1'b0; adr = 2'd0; data_in = 4'd0;
      tick(); tick();
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_out", {28'd0, RAM_out}, 32'd0);

      // reset release
      rst_n = 1'b1;
      #1;
      sweep("rel");
      for (int i = 0; i < 4; i++) rd("rel_rd", i[1:0], 4'h0);

      // write/read
      wr(2'd0, 4'hA);
      wr(2'd1, 4'h5);
      wr(2'd3, 4'hF);
      rd("wr_rd0", 2'd0, 4'hA);
      rd("wr_rd1", 2'd1, 4'h5);
      rd("wr_rd2", 2'd2, 4'h0);
      rd("wr_rd3", 2'd3, 4'hF);
`ifndef LMC_RAM_REG_OUT_EN
      // read-during-write: old value before the edge, new after
      adr = 2'd0; data_in = 4'h3; we = 1'b1;
      #1;
      check("rdw_old", {28'd0, RAM_out}, 32'hA);
      tick();
      we = 1'b0;
      check("rdw_new", {28'd0, RAM_out}, 32'h3);
`endif

      // clear request
      adr = 2'd3;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_busy", {31'd0, busy}, 32'd1);
      sweep("clr");
      for (int i = 0; i < 4; i++) rd("clr_rd", i[1:0], 4'h0);

      // simultaneous clr and we: clr wins
      adr = 2'd2; data_in = 4'h7; we = 1'b1; clr = 1'b1;
      tick();
      we = 1'b0; clr = 1'b0;
      check("cw_busy", {31'd0, busy}, 32'd1);
      sweep("cw");
      rd("cw_rd2", 2'd2, 4'h0);

      // writes and clr during a sweep are ignored
      wr(2'd1, 4'h9);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      adr = 2'd1; data_in = 4'h9; we = 1'b1;
      n = 0;
      while (busy && n < 20) begin
         clr = (n == 1) ? 1'b1 : 1'b0;
         tick();
         n++;
      end
      we = 1'b0; clr = 1'b0;
      check("wdc_len", n, 32'd4);
      check("wdc_done", {31'd0, busy}, 32'd0);
      rd("wdc_rd1", 2'd1, 4'h0);

      // reset mid-sweep
      wr(2'd3, 4'hB);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      #1;
      check("mid_busy0", {31'd0, busy}, 32'd1);
      check("mid_out0", {28'd0, RAM_out}, 32'd0);
      tick();
      check("mid_busy1", {31'd0, busy}, 32'd1);
      check("mid_out1", {28'd0, RAM_out}, 32'd0);
      rst_n = 1'b1;
      #1;
      sweep("mid");
      for (int i = 0; i < 4; i++) rd("mid_rd", i[1:0], 4'h0);
      wr(2'd2, 4'h6);
      rd("fin_rd2", 2'd2, 4'h6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
